addf_acc_ctrl: RTL and testbench
================================

ADDF_ACC_CTRL -- requirements
Module: addf_acc_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: operand, accumulator and adder-port width.
REQ-002 The block SHALL take parameter CNT_W, default 8: width of the accepted-operand counter.
REQ-003 The block SHALL take parameter SATURATE, default 0: 1 clamps the accumulator to all-ones on carry-out; 0 wraps.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 in_data  input  WIDTH  operand to add.
REQ-009 in_last  input  1  operand is the final one of the current frame.
REQ-010 add_a  output  WIDTH  A operand to the external CC_ADDF ripple adder.
REQ-011 add_b  output  WIDTH  B operand to the external adder.
REQ-012 add_ci  output  1  carry-in to the external adder.
REQ-013 add_s  input  WIDTH  sum returned by the external adder, same cycle.
REQ-014 add_co  input  1  carry-out returned by the external adder, same cycle.
REQ-015 out_valid  output  1  frame result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_sum  output  WIDTH  frame accumulated sum.
REQ-018 out_ovf  output  1  at least one carry-out occurred in the frame.
REQ-019 out_count  output  CNT_W  operands accepted in the frame, saturating at 2^CNT_W-1.

Function
REQ-020 The block SHALL implement two states: ACC (accumulating) and DONE (result held).
REQ-021 In ACC, in_ready SHALL be 1 and out_valid 0; in DONE, in_ready SHALL be 0 and out_valid 1.
REQ-022 add_a SHALL equal the accumulator register, add_b SHALL equal in_data and add_ci SHALL be 0 in every cycle, combinationally.
REQ-023 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge; in_data SHALL be ignored otherwise.
REQ-024 On a transfer with SATURATE=0, acc SHALL load add_s.
REQ-025 On a transfer with SATURATE=1, acc SHALL load all-ones if add_co=1, else add_s.
REQ-026 On a transfer, ovf SHALL become ovf OR add_co (sticky within the frame).
REQ-027 On a transfer, count SHALL increment by 1 unless already all-ones, where it holds.
REQ-028 A transfer with in_last=1 SHALL move ACC to DONE on the same edge, after applying REQ-024..027; latency from final operand to out_valid = 1 cycle.
REQ-029 In DONE, out_sum, out_ovf and out_count SHALL hold stable until out_valid and out_ready are both 1 on an edge.
REQ-030 On DONE handshake, acc, ovf and count SHALL clear to 0 and the state SHALL return to ACC; the next operand is accepted the following cycle earliest (one bubble).
REQ-031 out_ready while in ACC SHALL have no effect; in_valid while in DONE SHALL not transfer.
REQ-032 A frame of a single operand with in_last=1 SHALL be valid: out_sum = operand, out_count = 1.
REQ-033 out_sum, out_ovf and out_count SHALL be driven directly from acc, ovf and count registers in all states.

Reset
REQ-034 While rst_n=0, the state SHALL be ACC and acc, ovf and count SHALL be 0, giving in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_count=0, add_a=0, add_ci=0.
REQ-035 Reset asserted mid-frame or in DONE SHALL discard the partial or held result with no output handshake.
REQ-036 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-037 Frame 0x0001, 0x0002, 0x0003(last), out_ready=1 -> out_valid one cycle after the last, out_sum=0x0006, out_ovf=0, out_count=3, then ACC with acc=0.
REQ-038 SATURATE=0, frame 0xFFFF, 0x0002(last) -> out_sum=0x0001, out_ovf=1, out_count=2.
REQ-039 SATURATE=1, frame 0x8000, 0x8000, 0x0005(last) -> out_sum=0xFFFF, out_ovf=1, out_count=3.
REQ-040 Frame 0x1234(last) with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_sum=0x1234 held, in_ready=0, no extra transfer; handshake on cycle 6 clears state.
REQ-041 Assert rst_n=0 after two operands 0x0010, 0x0020 -> all outputs immediately 0 and in_ready=1; next frame 0x0007(last) -> out_sum=0x0007, out_count=1.
REQ-042 CNT_W=8, frame of 300 operands of 0x0001 -> out_count=255, out_sum=0x012C, out_ovf=0.

Source files
------------

// File: rtl/addf_acc_ctrl.sv
// Frame accumulator controller driving an external CC_ADDF ripple adder.
// Sums operands per frame and holds the result until the consumer accepts it.
module addf_acc_ctrl #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s, input logic co);
    if (SATURATE && co) return '1;
    return s;
  endfunction

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign add_ci    = 1'b0;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sat_sum(add_s, add_co);
          ovf_d = ovf_q | add_co;
          // Count sticks at all-ones rather than wrapping.
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_addf_acc_ctrl.sv
// Bench for addf_acc_ctrl: wrapping and saturating instances share stimulus and
// are checked every cycle against a frame-level arithmetic model.
module tb_addf_acc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [15:0] in_data;

  logic [15:0] add_a[2], add_b[2], add_s[2], out_sum[2];
  logic        add_ci[2], add_co[2], in_ready[2], out_valid[2], out_ovf[2];
  logic [7:0]  out_count[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural models of the external ripple adders.
  assign {add_co[0], add_s[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]} + {16'd0, add_ci[0]};
  assign {add_co[1], add_s[1]} = {1'b0, add_a[1]} + {1'b0, add_b[1]} + {16'd0, add_ci[1]};

  addf_acc_ctrl #(.WIDTH(16), .CNT_W(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_last(in_last), .add_a(add_a[0]), .add_b(add_b[0]),
    .add_ci(add_ci[0]), .add_s(add_s[0]), .add_co(add_co[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(out_sum[0]),
    .out_ovf(out_ovf[0]), .out_count(out_count[0]));

  addf_acc_ctrl #(.WIDTH(16), .CNT_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_last(in_last), .add_a(add_a[1]), .add_b(add_b[1]),
    .add_ci(add_ci[1]), .add_s(add_s[1]), .add_co(add_co[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(out_sum[1]),
    .out_ovf(out_ovf[1]), .out_count(out_count[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: per instance, running sum, sticky carry, count, result-held flag.
  int unsigned m_acc[2];
  bit          m_ovf[2];
  int          m_cnt[2];
  bit          m_done[2];
  int unsigned raw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_done[i]) begin
          if (in_valid) begin
            raw = m_acc[i] + in_data;
            if (raw > 32'hFFFF) m_ovf[i] = 1;
            if (raw > 32'hFFFF && i == 1) m_acc[i] = 32'hFFFF;
            else m_acc[i] = raw % 65536;
            if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            if (in_last) m_done[i] = 1;
          end
        end else if (out_ready) begin
          m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready[%0d]", i), {31'd0, in_ready[i]}, {31'd0, !m_done[i]});
      chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]}, {31'd0, m_done[i]});
      chk($sformatf("out_sum[%0d]", i), {16'd0, out_sum[i]}, m_acc[i]);
      chk($sformatf("out_ovf[%0d]", i), {31'd0, out_ovf[i]}, {31'd0, m_ovf[i]});
      chk($sformatf("out_count[%0d]", i), {24'd0, out_count[i]}, m_cnt[i]);
      chk($sformatf("add_a[%0d]", i), {16'd0, add_a[i]}, m_acc[i]);
      chk($sformatf("add_b[%0d]", i), {16'd0, add_b[i]}, {16'd0, in_data});
      chk($sformatf("add_ci[%0d]", i), {31'd0, add_ci[i]}, 32'd0);
    end
  end

  // Inputs change 1 time unit after the falling edge, clear of both sampling points.
  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(negedge clk);
    #1;
  endtask

  task automatic pin(input int i, input string tag, input logic [15:0] sum,
                     input logic ovf, input logic [7:0] cnt, input logic vld);
    chk({tag, ".sum"}, {16'd0, out_sum[i]}, {16'd0, sum});
    chk({tag, ".ovf"}, {31'd0, out_ovf[i]}, {31'd0, ovf});
    chk({tag, ".cnt"}, {24'd0, out_count[i]}, {24'd0, cnt});
    chk({tag, ".vld"}, {31'd0, out_valid[i]}, {31'd0, vld});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    pin(0, "reset", 16'h0000, 1'b0, 8'd0, 1'b0);
    chk("reset.in_ready", {31'd0, in_ready[0]}, 32'd1);
    rst_n = 1'b1;

    // Basic three-operand frame
    drive(1, 16'h0001, 0, 1);
    drive(1, 16'h0002, 0, 1);
    drive(1, 16'h0003, 1, 1);
    pin(0, "f123", 16'h0006, 1'b0, 8'd3, 1'b1);
    drive(0, 16'h0000, 0, 1);
    pin(0, "f123.clr", 16'h0000, 1'b0, 8'd0, 1'b0);

    // Wrap vs saturate with one carry
    drive(1, 16'hFFFF, 0, 1);
    drive(1, 16'h0002, 1, 1);
    pin(0, "wrap", 16'h0001, 1'b1, 8'd2, 1'b1);
    pin(1, "wrap.sat", 16'hFFFF, 1'b1, 8'd2, 1'b1);
    drive(0, 16'h0000, 0, 1);

    // Saturate clamps and stays clamped
    drive(1, 16'h8000, 0, 1);
    drive(1, 16'h8000, 0, 1);
    drive(1, 16'h0005, 1, 1);
    pin(1, "sat", 16'hFFFF, 1'b1, 8'd3, 1'b1);
    pin(0, "sat.wrap", 16'h0005, 1'b1, 8'd3, 1'b1);
    drive(0, 16'h0000, 0, 1);

    // Single-operand frame held under back-pressure with in_valid asserted
    drive(1, 16'h1234, 1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 16'h5555, 0, 0);
      pin(0, "hold", 16'h1234, 1'b0, 8'd1, 1'b1);
      chk("hold.in_ready", {31'd0, in_ready[0]}, 32'd0);
    end
    drive(1, 16'h5555, 0, 1);
    pin(0, "hold.clr", 16'h0000, 1'b0, 8'd0, 1'b0);
    drive(0, 16'h0000, 0, 1);

    // Reset mid-frame discards the partial sum
    drive(1, 16'h0010, 0, 1);
    drive(1, 16'h0020, 0, 1);
    pin(0, "pre_rst", 16'h0030, 1'b0, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    pin(0, "midrst", 16'h0000, 1'b0, 8'd0, 1'b0);
    chk("midrst.in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("midrst.add_a", {16'd0, add_a[0]}, 32'd0);
    in_valid = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 16'h0007, 1, 1);
    pin(0, "postrst", 16'h0007, 1'b0, 8'd1, 1'b1);
    drive(0, 16'h0000, 0, 1);

    // Counter saturation over a 300-operand frame
    for (int k = 0; k < 299; k++) drive(1, 16'h0001, 0, 1);
    drive(1, 16'h0001, 1, 1);
    pin(0, "long", 16'h012C, 1'b0, 8'd255, 1'b1);
    drive(0, 16'h0000, 0, 1);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'(16'hF000 | 16'($urandom)) : 16'($urandom);
      drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 2) != 0));
    end
    drive(0, 16'h0000, 0, 1);
    drive(0, 16'h0000, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
